mem_write_checker: RTL

Synthesizable, parametrised self-check monitor for the single-cycle MIPS data-memory write port. Watches `memwrite`/`dataadr`/`writedata` from `top`. Compares each non-ignored write against a programmed table of expected address/data pairs, in order or in any order. Reports sticky pass/fail with a failure code, the failing write, and a timeout, so a bench or FPGA LED can judge a program run without hand-written negedge checks.

---
 rtl/mwc_pkg.sv | 23 ++
 rtl/mwc_exp_table.sv | 85 ++++++++
 rtl/mem_write_checker.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mwc_pkg.sv
// mwc_pkg: shared types and constants for the memory-write checker.
//   mwc_state_t : checker FSM state
//   mwc_fail_t  : 2-bit failure code reported on fail_code
//   IGN_CNT_W   : width of the saturating ignored-write counter
package mwc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PASS  = 2'd2,
    ST_FAIL  = 2'd3
  } mwc_state_t;

  typedef enum logic [1:0] {
    FC_NONE      = 2'd0,
    FC_MISMATCH  = 2'd1,
    FC_TIMEOUT   = 2'd2,
    FC_DUPLICATE = 2'd3
  } mwc_fail_t;

  localparam int IGN_CNT_W = 16;

endpackage

// File: rtl/mwc_exp_table.sv
// mwc_exp_table: expected address/data table plus matched bitmask.
//   clk, reset        : clock, synchronous active-low reset (clears table + mask)
//   prog_we/idx/addr/data : table write (caller gates by state)
//   clr_mask, set_en, set_idx : matched-bitmask control
//   addr, data        : monitored write being probed
//   ord_idx           : entry expected next in ordered mode
//   hit_any_unmatched : probe matches at least one unmatched entry
//   hit_idx           : lowest-index unmatched entry that matches
//   hit_matched_only  : probe matches only already-matched entries
//   hit_ordered       : probe matches entry[ord_idx]
module mwc_exp_table
  import mwc_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_EXP = 4,
  parameter int IDX_W   = 2,
  parameter int CNT_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_idx,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              clr_mask,
  input  logic              set_en,
  input  logic [IDX_W-1:0]  set_idx,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic [CNT_W-1:0]  ord_idx,
  output logic              hit_any_unmatched,
  output logic [IDX_W-1:0]  hit_idx,
  output logic              hit_matched_only,
  output logic              hit_ordered
);

  logic [NUM_EXP-1:0][ADDR_W-1:0] exp_addr;
  logic [NUM_EXP-1:0][DATA_W-1:0] exp_data;
  logic [NUM_EXP-1:0]             matched;
  logic [NUM_EXP-1:0]             hit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      exp_addr <= '0;
      exp_data <= '0;
      matched  <= '0;
    end else begin
      // Index compared per entry so an out-of-range prog_idx is a no-op.
      for (int i = 0; i < NUM_EXP; i++) begin
        if (prog_we && prog_idx == IDX_W'(i)) begin
          exp_addr[i] <= prog_addr;
          exp_data[i] <= prog_data;
        end
      end
      if (clr_mask)
        matched <= '0;
      else if (set_en)
        for (int i = 0; i < NUM_EXP; i++)
          if (set_idx == IDX_W'(i)) matched[i] <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_EXP; g++) begin : g_hit
    assign hit[g] = (exp_addr[g] == addr) && (exp_data[g] == data);
  end

  always_comb begin
    hit_any_unmatched = 1'b0;
    hit_idx           = '0;
    hit_ordered       = 1'b0;
    // Walk downward so the lowest matching index is the last one assigned.
    for (int i = NUM_EXP - 1; i >= 0; i--) begin
      if (hit[i] && !matched[i]) begin
        hit_any_unmatched = 1'b1;
        hit_idx           = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_EXP; i++)
      if (hit[i] && ord_idx == CNT_W'(i)) hit_ordered = 1'b1;
  end

  assign hit_matched_only = (|hit) && !hit_any_unmatched;

endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: monitors the data-memory write port and judges a program
// run against a programmed table of expected (address, data) writes.
//   clk, reset         : clock, synchronous active-low reset
//   start              : pulse, clear status/counters and arm
//   prog_we/idx/addr/data : expected-table write (ignored while armed)
//   memwrite, dataadr, writedata : monitored write port
//   armed, done, pass  : run status (done/pass sticky)
//   fail_code          : 0 none, 1 mismatch, 2 timeout, 3 duplicate
//   fail_addr/data     : offending write (zero on timeout)
//   match_cnt, ign_cnt, cycle_cnt : progress counters
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NUM_EXP  = 4,
  parameter int ORDERED  = 1,
  parameter int IGN_BASE = 80,
  parameter int IGN_SIZE = 4,
  parameter int TIMEOUT  = 1024,
  localparam int IDX_W   = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
  localparam int CNT_W   = $clog2(NUM_EXP + 1),
  localparam int CYC_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 prog_we,
  input  logic [IDX_W-1:0]     prog_idx,
  input  logic [ADDR_W-1:0]    prog_addr,
  input  logic [DATA_W-1:0]    prog_data,
  input  logic                 memwrite,
  input  logic [ADDR_W-1:0]    dataadr,
  input  logic [DATA_W-1:0]    writedata,
  output logic                 armed,
  output logic                 done,
  output logic                 pass,
  output logic [1:0]           fail_code,
  output logic [ADDR_W-1:0]    fail_addr,
  output logic [DATA_W-1:0]    fail_data,
  output logic [CNT_W-1:0]     match_cnt,
  output logic [IGN_CNT_W-1:0] ign_cnt,
  output logic [CYC_W-1:0]     cycle_cnt
);

  mwc_state_t state, state_next;

  logic              hit_any_unmatched, hit_matched_only, hit_ordered;
  logic [IDX_W-1:0]  hit_idx;
  logic [ADDR_W:0]   ign_off;
  logic              in_ign, wr_chk, wr_hit, complete, timeout;
  mwc_fail_t         wr_code;
  logic              tbl_we, active, inc_match, inc_ign, cap_write, cap_timeout, set_pass;

  // Extra bit keeps the window test correct near the top of the address space.
  assign ign_off  = {1'b0, dataadr} - (ADDR_W+1)'(IGN_BASE);
  assign in_ign   = (IGN_SIZE != 0) && (dataadr >= ADDR_W'(IGN_BASE)) &&
                    (ign_off < (ADDR_W+1)'(IGN_SIZE));
  assign wr_chk   = memwrite && !in_ign;
  assign wr_hit   = (ORDERED != 0) ? hit_ordered : hit_any_unmatched;
  assign wr_code  = ((ORDERED == 0) && hit_matched_only) ? FC_DUPLICATE : FC_MISMATCH;
  assign complete = wr_chk && wr_hit && (match_cnt == CNT_W'(NUM_EXP - 1));
  assign timeout  = (cycle_cnt == CYC_W'(TIMEOUT - 1));

  mwc_exp_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NUM_EXP(NUM_EXP),
    .IDX_W  (IDX_W),
    .CNT_W  (CNT_W)
  ) u_table (
    .clk              (clk),
    .reset            (reset),
    .prog_we          (tbl_we),
    .prog_idx         (prog_idx),
    .prog_addr        (prog_addr),
    .prog_data        (prog_data),
    .clr_mask         (start),
    .set_en           (inc_match),
    .set_idx          (hit_idx),
    .addr             (dataadr),
    .data             (writedata),
    .ord_idx          (match_cnt),
    .hit_any_unmatched(hit_any_unmatched),
    .hit_idx          (hit_idx),
    .hit_matched_only (hit_matched_only),
    .hit_ordered      (hit_ordered)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start)
      state_next = ST_ARMED;
    else if (state == ST_ARMED) begin
      if (wr_chk && !wr_hit) state_next = ST_FAIL;
      else if (complete)     state_next = ST_PASS;
      else if (timeout)      state_next = ST_FAIL;
    end
  end

  // Control strobes; a completing match beats a timeout on the same cycle.
  always_comb begin
    tbl_we      = prog_we && (state != ST_ARMED);
    active      = (state == ST_ARMED) && !start;
    inc_match   = active && wr_chk && wr_hit;
    inc_ign     = active && memwrite && in_ign;
    cap_write   = active && wr_chk && !wr_hit;
    set_pass    = active && complete;
    cap_timeout = active && timeout && !cap_write && !set_pass;
  end

  always_ff @(posedge clk) begin
    if (!reset || start) begin
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= FC_NONE;
      fail_addr <= '0;
      fail_data <= '0;
      match_cnt <= '0;
      ign_cnt   <= '0;
      cycle_cnt <= '0;
    end else if (state == ST_ARMED) begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (inc_match) match_cnt <= match_cnt + 1'b1;
      if (inc_ign && ign_cnt != '1) ign_cnt <= ign_cnt + 1'b1;
      if (cap_write) begin
        done      <= 1'b1;
        fail_code <= wr_code;
        fail_addr <= dataadr;
        fail_data <= writedata;
      end
      if (cap_timeout) begin
        done      <= 1'b1;
        fail_code <= FC_TIMEOUT;
      end
      if (set_pass) begin
        done <= 1'b1;
        pass <= 1'b1;
      end
    end
  end

  assign armed = (state == ST_ARMED);

endmodule
